// File: rtl/overlay_pkg.sv
// ============================================================================
//  Module      : overlay_pkg
//  Description : Shared types and defaults for the overlay fetch block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package overlay_pkg;

    // Default prefetch depth: 4 words of 32 bits, i.e. 8 pixels
    localparam int unsigned c_depth_log2_default = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        PRIME  = 2'd2,
        STREAM = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgba4_t;

endpackage

`default_nettype wire

// File: rtl/overlay_fifo.sv
// ============================================================================
//  Module      : overlay_fifo
//  Description : Synchronous prefetch FIFO with flush, first-word fall-through
//                read port and full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module overlay_fifo
    import overlay_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = c_depth_log2_default,
    parameter int unsigned WIDTH      = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned c_depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Count never exceeds depth, so its MSB alone marks full
    assign full  = r_count[DEPTH_LOG2];
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{DEPTH_LOG2{1'b0}}, w_do_push}
                               - {{DEPTH_LOG2{1'b0}}, w_do_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/overlay_fetch.sv
// ============================================================================
//  Module      : overlay_fetch
//  Description : Overlay image loader and pixel streamer. Packs downloaded
//                bytes into 16-bit SDRAM writes, and during video prefetches
//                32-bit words into a FIFO that feeds one RGBA4 pixel per
//                active pixel enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module overlay_fetch
    import overlay_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = c_depth_log2_default
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        vsync,
    input  logic        enable,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        mem_req,
    output logic        mem_rnw,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_valid,
    output logic [15:0] pix_rgba,
    output logic        underrun
);

    state_e      r_state;
    logic        r_vsync_d;
    logic [22:0] r_word_cnt;
    logic        r_outstanding;
    logic        r_discard;
    logic        r_half;
    logic [7:0]  r_lo_byte;
    logic        r_mem_req;
    logic        r_mem_rnw;
    logic [23:0] r_mem_addr;
    logic [15:0] r_mem_din;
    rgba4_t      r_pix;
    logic        r_underrun;

    logic        w_vsync_rise;
    logic        w_active;
    logic        w_streaming;
    logic        w_flush;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_pix_req;
    logic        w_issue;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;

    assign w_vsync_rise = vsync & ~r_vsync_d;
    assign w_active     = ~(hblank | vblank);
    // Streaming continues this cycle only if nothing forces a state change
    assign w_streaming  = (r_state == STREAM) & ~dl_active & enable & ~w_vsync_rise;
    assign w_flush      = ~w_streaming;
    assign w_rsp        = mem_valid & r_outstanding;
    assign w_push       = w_rsp & ~r_discard & w_streaming;
    assign w_pix_req    = w_streaming & ce_pix & w_active;
    assign w_pop        = w_pix_req & ~w_empty & r_half;
    assign w_issue      = w_streaming & ~r_outstanding & ~w_full;

    overlay_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (w_flush),
        .push  (w_push),
        .wdata (mem_dout),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Track the single in-flight read; a read abandoned by a flush is dropped on return
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (w_rsp) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_outstanding <= 1'b1;
            end
            if (w_flush && r_outstanding) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Main state machine with registered memory and pixel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_vsync_d  <= 1'b0;
            r_word_cnt <= '0;
            r_half     <= 1'b0;
            r_lo_byte  <= '0;
            r_mem_req  <= 1'b0;
            r_mem_rnw  <= 1'b1;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_pix      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_mem_req <= 1'b0;
            if (dl_active) begin
                r_state <= WRITE;
                r_pix   <= '0;
                r_half  <= 1'b0;
                if (r_state == WRITE && dl_wr) begin
                    if (!dl_addr[0]) begin
                        r_lo_byte <= dl_data;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_rnw  <= 1'b0;
                        r_mem_addr <= dl_addr[24:1];
                        r_mem_din  <= {dl_data, r_lo_byte};
                    end
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_pix <= '0;
                        if (enable && w_vsync_rise) begin
                            r_state <= PRIME;
                        end
                    end
                    WRITE: begin
                        // A low byte left without its partner is discarded here
                        r_lo_byte <= '0;
                        r_state   <= IDLE;
                    end
                    PRIME: begin
                        r_word_cnt <= '0;
                        r_underrun <= 1'b0;
                        r_half     <= 1'b0;
                        if (enable) begin
                            r_state <= STREAM;
                        end else begin
                            r_state <= IDLE;
                            r_pix   <= '0;
                        end
                    end
                    STREAM: begin
                        if (!enable) begin
                            r_state <= IDLE;
                            r_pix   <= '0;
                            r_half  <= 1'b0;
                        end else if (w_vsync_rise) begin
                            r_state <= PRIME;
                            r_half  <= 1'b0;
                        end else begin
                            if (w_issue) begin
                                r_mem_req  <= 1'b1;
                                r_mem_rnw  <= 1'b1;
                                r_mem_addr <= {r_word_cnt, 1'b0};
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                            if (w_pix_req) begin
                                if (w_empty) begin
                                    r_pix      <= '0;
                                    r_underrun <= 1'b1;
                                end else begin
                                    r_pix  <= r_half ? rgba4_t'(w_head[31:16])
                                                     : rgba4_t'(w_head[15:0]);
                                    r_half <= ~r_half;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_rnw  = r_mem_rnw;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign pix_rgba = r_pix;
    assign underrun = r_underrun;

endmodule

`default_nettype wire
